// File: rtl/sipo_pkg.sv
// ============================================================================
// Module  : sipo_pkg
// Brief   : Shared types and bit-order constants for the serial link.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sipo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  // Shared with piso so both link ends agree on bit order.
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sipo_shreg.sv
// ============================================================================
// Module  : sipo_shreg
// Brief   : Bidirectional shift register; clr_load starts a fresh word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_shreg
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_load,
  input  logic             dir,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // The first bit enters at the end it shifts away from, so after WIDTH bits
  // it lands in q[WIDTH-1] (MSB first) or q[0] (LSB first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr_load) begin
      if (dir == DIR_LSB_FIRST)
        q <= {sin, {(WIDTH-1){1'b0}}};
      else
        q <= {{(WIDTH-1){1'b0}}, sin};
    end else if (en) begin
      if (dir == DIR_LSB_FIRST)
        q <= {sin, q[WIDTH-1:1]};
      else
        q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

`default_nettype wire

// File: rtl/sipo_rx.sv
// ============================================================================
// Module  : sipo_rx
// Brief   : Serial-in/parallel-out receiver with framing-restart detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  input  logic             direction,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  sipo_state_t      r_state;
  sipo_state_t      w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_dir_q;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_frame_err;

  logic             w_load;
  logic             w_shift;
  logic             w_done;
  logic             w_restart;
  logic             w_dir;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A start always wins, including on the edge carrying the last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      IDLE: begin
        if (sin_valid && start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          if (start) begin
            w_load    = 1'b1;
            w_restart = 1'b1;
          end else if (r_cnt == C_LAST) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_dir = w_load ? direction : r_dir_q;

  sipo_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .en       (w_shift),
    .clr_load (w_load),
    .dir      (w_dir),
    .sin      (sin),
    .q        (w_q)
  );

  // Final bit goes straight into dout rather than through the shift register.
  assign w_word = (r_dir_q == DIR_LSB_FIRST) ? {sin, w_q[WIDTH-1:1]}
                                             : {w_q[WIDTH-2:0], sin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_dir_q      <= DIR_MSB_FIRST;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_dout_valid <= w_done;
      r_frame_err  <= w_restart;
      if (w_load) begin
        r_cnt   <= CW'(1);
        r_dir_q <= direction;
      end else if (w_done) begin
        r_cnt  <= '0;
        r_dout <= w_word;
      end else if (w_shift) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state == SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx.sv
// ============================================================================
// Module  : tb_sipo_rx
// Brief   : Directed bench for sipo_rx with a queue-based event scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       start = 1'b0;
  logic       direction = 1'b0;
  logic [3:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       frame_err;

  typedef struct packed {
    logic       fe;
    logic [3:0] word;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_valid_cyc = 0;
  int  prev_valid_cyc = 0;

  sipo_rx #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .start      (start),
    .direction  (direction),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic b, input logic st, input logic d);
    @(negedge clk);
    sin = b; sin_valid = 1'b1; start = st; direction = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sin_valid = 1'b0; start = 1'b0; sin = 1'b0;
    end
  endtask

  // Monitor: every strobe must match the next expected event in order.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (dout_valid && frame_err) begin
        chk("valid_and_frame_err_together", 32'd1, 32'd0);
      end else if (dout_valid || frame_err) begin
        if (dout_valid) begin
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_event_fe", {31'd0, frame_err}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind_fe", {31'd0, frame_err}, {31'd0, e.fe});
          chk("event_dout", {28'd0, dout}, {28'd0, e.word});
        end
      end
    end
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_dout", {28'd0, dout}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    idle(2);

    // T1: MSB first 1,0,1,1 -> 1011 with timing checks
    exp_q.push_back('{fe: 1'b0, word: 4'b1011});
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("t1_busy_after_bit1", {31'd0, busy}, 32'd1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    chk("t1_busy_after_bit3", {31'd0, busy}, 32'd1);
    idle(1);
    chk("t1_valid_after_bit4", {31'd0, dout_valid}, 32'd1);
    chk("t1_busy_in_valid_cycle", {31'd0, busy}, 32'd0);
    idle(1);
    chk("t1_valid_one_cycle", {31'd0, dout_valid}, 32'd0);
    idle(1);

    // T2: LSB first 1,0,1,1 -> 1101
    exp_q.push_back('{fe: 1'b0, word: 4'b1101});
    send(1'b1, 1'b1, 1'b1);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    idle(2);

    // T3: MSB first 0,1,<3 idle>,1,0 -> 0110
    exp_q.push_back('{fe: 1'b0, word: 4'b0110});
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    idle(3);
    chk("t3_busy_in_gap", {31'd0, busy}, 32'd1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    idle(2);

    // T4: 1,1 then restart with 0,0,1,0 -> frame_err (dout held 0110), then 0010
    exp_q.push_back('{fe: 1'b1, word: 4'b0110});
    exp_q.push_back('{fe: 1'b0, word: 4'b0010});
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    idle(2);

    // T5: reset mid-word, then 1111
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; sin_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("t5_dout_in_reset", {28'd0, dout}, 32'd0);
    chk("t5_busy_in_reset", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(1);
    exp_q.push_back('{fe: 1'b0, word: 4'b1111});
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    idle(2);

    // T6: back-to-back 1001 (MSB) then LSB 0,1,1,1 -> 1110
    exp_q.push_back('{fe: 1'b0, word: 4'b1001});
    exp_q.push_back('{fe: 1'b0, word: 4'b1110});
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    idle(3);
    chk("t6_valid_spacing", last_valid_cyc - prev_valid_cyc, 32'd4);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
